data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 146 ++++++++++++++
 tb/tb_data_cache.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 16 one-word lines.
// Latency: hits complete in the request cycle; a miss costs one cycle plus the memory access time(s).
// Backpressure: dhit stays low until the request is served; memory dwait stretches WB/FETCH/FLUSH.
module data_cache (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);
    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, FLUSHED} state_t;

    state_t      state_q, state_d;
    logic [15:0] valid_q, valid_d;
    logic [15:0] dirty_q, dirty_d;
    logic [25:0] tag_q  [16];
    logic [25:0] tag_d  [16];
    logic [31:0] data_q [16];
    logic [31:0] data_d [16];
    logic [3:0]  fidx_q, fidx_d;

    logic [3:0]  idx;
    logic [25:0] req_tag;
    logic        hit;
    logic        fline_dirty;
    logic        unused_byte_bits;

    assign idx     = dmemaddr[5:2];
    assign req_tag = dmemaddr[31:6];
    // The byte offset never selects anything: the cache is word-granular.
    assign unused_byte_bits = ^dmemaddr[1:0];

    // Halt outranks any request, so a hit is only reported while not halting.
    assign hit = (state_q == IDLE) & valid_q[idx] & (tag_q[idx] == req_tag)
               & (dmemREN | dmemWEN) & ~halt;
    assign dhit        = hit;
    assign dmemload    = (hit & dmemREN) ? data_q[idx] : 32'h0;
    assign flushed     = (state_q == FLUSHED);
    assign fline_dirty = valid_q[fidx_q] & dirty_q[fidx_q];

    // Next-state, line update and memory-port drive for every state.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        fidx_d  = fidx_q;
        dREN    = 1'b0;
        dWEN    = 1'b0;
        daddr   = 32'h0;
        dstore  = 32'h0;
        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH;
                    fidx_d  = 4'd0;
                end else if (dmemREN | dmemWEN) begin
                    if (hit) begin
                        // Write wins when both strobes are up.
                        if (dmemWEN) begin
                            data_d[idx]  = dmemstore;
                            dirty_d[idx] = 1'b1;
                        end
                    end else if (valid_q[idx] & dirty_q[idx]) begin
                        state_d = WB;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = {tag_q[idx], idx, 2'b00};
                dstore = data_q[idx];
                if (!dwait) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = {dmemaddr[31:2], 2'b00};
                if (!dwait) begin
                    data_d[idx]  = dload;
                    tag_d[idx]   = req_tag;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = IDLE;
                end
            end
            FLUSH: begin
                if (fline_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = {tag_q[fidx_q], fidx_q, 2'b00};
                    dstore = data_q[fidx_q];
                end
                // Clean lines step on immediately; dirty ones wait for memory.
                if (!fline_dirty || !dwait) begin
                    dirty_d[fidx_q] = 1'b0;
                    if (fidx_q == 4'd15) begin
                        state_d = FLUSHED;
                    end else begin
                        fidx_d = fidx_q + 4'd1;
                    end
                end
            end
            FLUSHED: begin
                state_d = FLUSHED;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: cleared asynchronously, so outputs drop the moment nRST falls.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            fidx_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            fidx_q  <= fidx_d;
        end
    end

    // Tag and data storage: contents are meaningless until the valid bit is set.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache against a transaction-level cache/memory model.
// Every request runs until dhit; memory latency is random 0..2 unless forced.
// Summary counts every comparison and every miscompare.
module tb_data_cache;
    logic        CLK;
    logic        nRST;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    data_cache dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vecs = 0;
    int errs = 0;

    // Reference model: cache lines plus backing memory.
    bit          m_valid [16];
    bit          m_dirty [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    logic [31:0] mem [logic [31:0]];

    // Observed memory transactions.
    logic        t_we   [$];
    logic [31:0] t_addr [$];
    logic [31:0] t_dat  [$];
    int          t_lat  [$];

    bit          busy;
    int          lat, cur_lat;
    int          force_lat = -1;
    logic        s_dhit, s_flushed;
    logic [31:0] s_load;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // One clock cycle: answer memory, sample outputs, advance to posedge+1.
    task automatic step();
        #1;
        if (dREN || dWEN) begin
            if (!busy) begin
                busy    = 1'b1;
                lat     = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 2));
                cur_lat = lat;
            end
            if (lat == 0) begin
                dwait = 1'b0;
                dload = dREN ? mem_rd(daddr) : 32'h0;
                t_we.push_back(dWEN);
                t_addr.push_back(daddr);
                t_dat.push_back(dstore);
                t_lat.push_back(cur_lat);
                if (dWEN) mem[daddr] = dstore;
                busy = 1'b0;
            end else begin
                dwait = 1'b1;
                lat--;
            end
        end else begin
            dwait = 1'b1;
            dload = 32'h0;
            busy  = 1'b0;
        end
        #1;
        s_dhit    = dhit;
        s_load    = dmemload;
        s_flushed = flushed;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_txns();
        t_we.delete(); t_addr.delete(); t_dat.delete(); t_lat.delete();
    endtask

    task automatic do_reset();
        nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
        dwait = 1'b1; dload = 32'h0; busy = 1'b0; force_lat = -1;
        for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic do_req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        logic [3:0]  ix;
        logic [25:0] tg;
        logic        e_we   [$];
        logic [31:0] e_addr [$];
        logic [31:0] e_dat  [$];
        logic [31:0] e_load;
        bit          done;
        int          n, exp_cyc;
        ix = a[5:2];
        tg = a[31:6];
        if (!(m_valid[ix] && m_tag[ix] == tg)) begin
            if (m_valid[ix] && m_dirty[ix]) begin
                e_we.push_back(1'b1); e_addr.push_back({m_tag[ix], ix, 2'b00}); e_dat.push_back(m_data[ix]);
            end
            e_we.push_back(1'b0); e_addr.push_back({a[31:2], 2'b00}); e_dat.push_back(32'h0);
            m_valid[ix] = 1; m_tag[ix] = tg; m_dirty[ix] = 0;
            m_data[ix]  = mem_rd({a[31:2], 2'b00});
        end
        e_load = m_data[ix];
        if (w) begin m_data[ix] = d; m_dirty[ix] = 1; end
        clear_txns();
        dmemREN = r; dmemWEN = w; dmemaddr = a; dmemstore = d;
        n = 0; done = 0;
        while (!done && n < 40) begin
            step();
            n++;
            done = s_dhit;
        end
        dmemREN = 1'b0; dmemWEN = 1'b0;
        chk("req_done", 32'(done), 32'd1);
        chk("txn_count", t_we.size(), e_we.size());
        exp_cyc = (e_we.size() == 0) ? 1 : 2;
        for (int i = 0; i < t_we.size() && i < e_we.size(); i++) begin
            chk("txn_we", 32'(t_we[i]), 32'(e_we[i]));
            chk("txn_addr", t_addr[i], e_addr[i]);
            if (e_we[i]) chk("txn_data", t_dat[i], e_dat[i]);
        end
        for (int i = 0; i < t_lat.size(); i++) exp_cyc += t_lat[i] + 1;
        if (done) begin
            chk("hit_cycles", n, exp_cyc);
            if (r && !w) chk("load", s_load, e_load);
        end
    endtask

    task automatic do_flush();
        logic [31:0] e_addr [$];
        logic [31:0] e_dat  [$];
        bit          done;
        int          n, exp_cyc;
        for (int i = 0; i < 16; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                e_addr.push_back({m_tag[i], 4'(i), 2'b00});
                e_dat.push_back(m_data[i]);
                m_dirty[i] = 0;
            end
        end
        clear_txns();
        halt = 1'b1;
        n = 0; done = 0;
        while (!done && n < 300) begin
            step();
            n++;
            done = s_flushed;
        end
        chk("flush_done", 32'(done), 32'd1);
        chk("flush_count", t_we.size(), e_addr.size());
        for (int i = 0; i < t_we.size() && i < e_addr.size(); i++) begin
            chk("flush_we", 32'(t_we[i]), 32'd1);
            chk("flush_addr", t_addr[i], e_addr[i]);
            chk("flush_data", t_dat[i], e_dat[i]);
        end
        exp_cyc = 2 + 16 - e_addr.size();
        for (int i = 0; i < t_lat.size(); i++) exp_cyc += t_lat[i] + 1;
        if (done) chk("flush_cycles", n, exp_cyc);
        // FLUSHED must ignore requests and stay put.
        clear_txns();
        dmemREN = 1'b1; dmemaddr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flushed_dhit", 32'(s_dhit), 32'd0);
            chk("flushed_hold", 32'(s_flushed), 32'd1);
        end
        chk("flushed_traffic", t_we.size(), 0);
        dmemREN = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        nRST = 1'b0; dmemREN = 1'b1; dmemWEN = 1'b0; dmemaddr = 32'h0; dmemstore = 32'h0;
        halt = 1'b0; dwait = 1'b1; dload = 32'h0;
        #2;
        chk("rst_dhit", 32'(dhit), 32'd0);
        chk("rst_flushed", 32'(flushed), 32'd0);
        chk("rst_dREN", 32'(dREN), 32'd0);
        chk("rst_dWEN", 32'(dWEN), 32'd0);
        chk("rst_daddr", daddr, 32'h0);
        chk("rst_dstore", dstore, 32'h0);
        chk("rst_dmemload", dmemload, 32'h0);
        do_reset();

        // Cold read with two wait cycles, then write hit, read hit, conflict miss, dual strobe.
        mem[32'h40] = 32'hDEADBEEF;
        force_lat = 2;
        do_req(1'b0, 1'b1, 32'h40, 32'h0);
        chk("cold_load", s_load, 32'hDEADBEEF);
        force_lat = -1;
        do_req(1'b1, 1'b0, 32'h40, 32'h12345678);
        do_req(1'b0, 1'b1, 32'h40, 32'h0);
        chk("wr_rd_load", s_load, 32'h12345678);
        do_req(1'b0, 1'b1, 32'h80, 32'h0);
        do_req(1'b1, 1'b1, 32'h80, 32'hCAFEF00D);
        do_req(1'b0, 1'b1, 32'h80, 32'h0);
        chk("both_load", s_load, 32'hCAFEF00D);

        // Two dirty lines at the extremes of the index range.
        do_reset();
        do_req(1'b1, 1'b0, 32'h40, 32'h11111111);
        do_req(1'b1, 1'b0, 32'h7C, 32'h22222222);
        do_flush();

        // Reset in the middle of a stalled fetch.
        do_reset();
        force_lat = 20;
        dmemREN = 1'b1; dmemWEN = 1'b0; dmemaddr = 32'h100;
        step();
        step();
        chk("fetch_dREN", 32'(dREN), 32'd1);
        chk("fetch_daddr", daddr, 32'h100);
        nRST = 1'b0;
        #1;
        chk("midrst_dREN", 32'(dREN), 32'd0);
        chk("midrst_daddr", daddr, 32'h0);
        chk("midrst_dhit", 32'(dhit), 32'd0);
        do_reset();
        do_req(1'b0, 1'b1, 32'h100, 32'h0);

        // Random traffic over a few tags to provoke conflicts and writebacks.
        for (int round = 0; round < 3; round++) begin
            do_reset();
            for (int k = 0; k < 60; k++) begin
                a  = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                op = int'($urandom_range(0, 2));
                do_req(op != 0, op != 1, a, $urandom);
            end
            do_flush();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
